// File: rtl/mips_run_pkg.sv
// Shared definitions for the mips run controller: run-state encoding and its width.
package mips_run_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_HOLD    = 3'd1,
    ST_RUN     = 3'd2,
    ST_DONE    = 3'd3,
    ST_TIMEOUT = 3'd4
  } run_state_t;

endpackage

// File: rtl/mips_halt_detect.sv
// Program-end detector: flags the HALT_REPEAT-th consecutive commit at one PC,
// or a commit at the programmable end PC. The halt output is combinational.
module mips_halt_detect #(
  parameter int PC_W        = 32,
  parameter int HALT_REPEAT = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            enable,
  input  logic            end_pc_en,
  input  logic [PC_W-1:0] end_pc,
  input  logic            commit_valid,
  input  logic [PC_W-1:0] commit_pc,
  output logic            halt
);

  localparam int REP_W = $clog2(HALT_REPEAT + 1);
  localparam logic [REP_W-1:0] REP_HALT = REP_W'(HALT_REPEAT);
  localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

  logic [PC_W-1:0]  last_pc;
  logic [REP_W-1:0] rep;
  logic [REP_W-1:0] rep_next;
  logic             commit;
  logic             repeat_hit;
  logic             end_hit;

  assign commit = enable & commit_valid;

  // Saturate at the halt count so the tracker can never wrap.
  always_comb begin
    rep_next = REP_ONE;
    if (commit_pc == last_pc) begin
      rep_next = (rep == REP_HALT) ? REP_HALT : rep + REP_ONE;
    end
  end

  assign repeat_hit = (rep_next == REP_HALT);
  assign end_hit    = end_pc_en & (commit_pc == end_pc);
  assign halt       = commit & (repeat_hit | end_hit);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_pc <= '0;
      rep     <= '0;
    end else if (clear) begin
      last_pc <= '0;
      rep     <= '0;
    end else if (commit) begin
      last_pc <= commit_pc;
      rep     <= rep_next;
    end
  end

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller for the pipelined mips core: sequences core reset, counts RUN
// cycles and commits, and ends the run on halt/end PC or the cycle watchdog.
module mips_run_ctrl
  import mips_run_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int CNT_W       = 32,
  parameter int RST_CYCLES  = 4,
  parameter int HALT_REPEAT = 3,
  parameter int MAX_CYCLES  = 500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             end_pc_en,
  input  logic [PC_W-1:0]  end_pc,
  input  logic             commit_valid,
  input  logic [PC_W-1:0]  commit_pc,
  output logic             cpu_reset,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int HOLD_W = $clog2(RST_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(RST_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);
  localparam logic [CNT_W-1:0]  CYCLE_LAST = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

  run_state_t        state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              in_hold;
  logic              in_run;
  logic              halt;

  assign in_hold = (state == ST_HOLD);
  assign in_run  = (state == ST_RUN);

  mips_halt_detect #(
    .PC_W        (PC_W),
    .HALT_REPEAT (HALT_REPEAT)
  ) u_halt_detect (
    .clk          (clk),
    .reset        (reset),
    .clear        (in_hold),
    .enable       (in_run),
    .end_pc_en    (end_pc_en),
    .end_pc       (end_pc),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc),
    .halt         (halt)
  );

  // Halt is checked before the watchdog so a halt on the last allowed cycle ends as DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      hold_cnt  <= '0;
      cpu_reset <= 1'b1;
      running   <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_TIMEOUT: begin
          if (start) begin
            state     <= ST_HOLD;
            hold_cnt  <= '0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            timeout   <= 1'b0;
            cycle_cnt <= '0;
            instr_cnt <= '0;
          end
        end
        ST_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state     <= ST_RUN;
            cpu_reset <= 1'b0;
            running   <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HOLD_ONE;
          end
        end
        ST_RUN: begin
          cycle_cnt <= cycle_cnt + CNT_ONE;
          if (commit_valid) begin
            instr_cnt <= instr_cnt + CNT_ONE;
          end
          if (halt) begin
            state     <= ST_DONE;
            done      <= 1'b1;
            cpu_reset <= 1'b1;
            running   <= 1'b0;
          end else if (cycle_cnt == CYCLE_LAST) begin
            state     <= ST_TIMEOUT;
            timeout   <= 1'b1;
            cpu_reset <= 1'b1;
            running   <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          cpu_reset <= 1'b1;
          running   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Self-checking bench for mips_run_ctrl: a run-level model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mips_run_ctrl;

  localparam int PC_W        = 32;
  localparam int CNT_W       = 32;
  localparam int RST_CYCLES  = 4;
  localparam int HALT_REPEAT = 3;
  localparam int MAX_CYCLES  = 100;

  logic             clk          = 1'b0;
  logic             reset        = 1'b1;
  logic             start        = 1'b0;
  logic             end_pc_en    = 1'b0;
  logic [PC_W-1:0]  end_pc       = '0;
  logic             commit_valid = 1'b0;
  logic [PC_W-1:0]  commit_pc    = '0;
  logic             cpu_reset;
  logic             running;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instr_cnt;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  mips_run_ctrl #(
    .PC_W        (PC_W),
    .CNT_W       (CNT_W),
    .RST_CYCLES  (RST_CYCLES),
    .HALT_REPEAT (HALT_REPEAT),
    .MAX_CYCLES  (MAX_CYCLES)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .end_pc_en    (end_pc_en),
    .end_pc       (end_pc),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc),
    .cpu_reset    (cpu_reset),
    .running      (running),
    .done         (done),
    .timeout      (timeout),
    .cycle_cnt    (cycle_cnt),
    .instr_cnt    (instr_cnt)
  );

  always #5 clk = ~clk;

  // Run-level model: a run is either holding the core, running, or stopped.
  bit               m_run       = 1'b0;
  bit               m_done      = 1'b0;
  bit               m_timeout   = 1'b0;
  int               m_hold_left = 0;
  int               m_cycles    = 0;
  int               m_instrs    = 0;
  int               m_rep       = 0;
  bit               m_halt      = 1'b0;
  logic [PC_W-1:0]  m_hist[$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_run       = 1'b0;
      m_done      = 1'b0;
      m_timeout   = 1'b0;
      m_hold_left = 0;
      m_cycles    = 0;
      m_instrs    = 0;
      m_hist.delete();
    end else if (m_run) begin
      m_cycles++;
      m_halt = 1'b0;
      if (commit_valid) begin
        m_instrs++;
        m_hist.push_back(commit_pc);
        m_rep = 0;
        for (int i = m_hist.size() - 1; i >= 0; i--) begin
          if (m_hist[i] != commit_pc) break;
          m_rep++;
        end
        if (m_rep >= HALT_REPEAT || (end_pc_en && commit_pc == end_pc)) m_halt = 1'b1;
      end
      if (m_halt) begin
        m_run  = 1'b0;
        m_done = 1'b1;
      end else if (m_cycles == MAX_CYCLES) begin
        m_run     = 1'b0;
        m_timeout = 1'b1;
      end
    end else if (m_hold_left > 0) begin
      m_hold_left--;
      if (m_hold_left == 0) m_run = 1'b1;
    end else if (start) begin
      m_hold_left = RST_CYCLES;
      m_done      = 1'b0;
      m_timeout   = 1'b0;
      m_cycles    = 0;
      m_instrs    = 0;
      m_hist.delete();
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("model cpu_reset", 32'(cpu_reset), 32'(!m_run));
      checkOutput("model running",   32'(running),   32'(m_run));
      checkOutput("model done",      32'(done),      32'(m_done));
      checkOutput("model timeout",   32'(timeout),   32'(m_timeout));
      checkOutput("model cycle_cnt", cycle_cnt,      32'(m_cycles));
      checkOutput("model instr_cnt", instr_cnt,      32'(m_instrs));
    end
  end

  task automatic applyStimulus(input logic s, input logic cv, input logic [PC_W-1:0] pc);
    start        = s;
    commit_valid = cv;
    commit_pc    = pc;
    @(negedge clk);
    start        = 1'b0;
    commit_valid = 1'b0;
  endtask

  task automatic runStart();
    applyStimulus(1'b1, 1'b0, '0);
    repeat (RST_CYCLES) applyStimulus(1'b0, 1'b0, '0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " cpu_reset"}, 32'(cpu_reset), 32'd1);
    checkOutput({tag, " running"},   32'(running),   32'd0);
    checkOutput({tag, " done"},      32'(done),      32'd0);
    checkOutput({tag, " timeout"},   32'(timeout),   32'd0);
    checkOutput({tag, " cycle_cnt"}, cycle_cnt,      32'd0);
    checkOutput({tag, " instr_cnt"}, instr_cnt,      32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global time limit reached at %0t", $time);
    $fatal(1, "[TB] bench did not finish");
  end

  initial begin
    #1 reset = 1'b0;
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    reset = 1'b1;

    $display("[TB] start after 5 idle cycles, core held for RST_CYCLES");
    repeat (5) applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0);
    repeat (RST_CYCLES - 1) applyStimulus(1'b0, 1'b0, '0);
    checkOutput("hold cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("hold running",   32'(running),   32'd0);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("run cpu_reset", 32'(cpu_reset), 32'd0);
    checkOutput("run running",   32'(running),   32'd1);

    $display("[TB] self-loop halt");
    applyStimulus(1'b0, 1'b1, 32'h3000);
    applyStimulus(1'b0, 1'b1, 32'h3004);
    applyStimulus(1'b0, 1'b1, 32'h3008);
    applyStimulus(1'b0, 1'b1, 32'h3008);
    checkOutput("loop early done", 32'(done), 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h3008);
    checkOutput("loop done",      32'(done),      32'd1);
    checkOutput("loop instr_cnt", instr_cnt,      32'd5);
    checkOutput("loop cycle_cnt", cycle_cnt,      32'd5);
    checkOutput("loop cpu_reset", 32'(cpu_reset), 32'd1);

    $display("[TB] end-PC halt");
    end_pc_en = 1'b1;
    end_pc    = 32'h3010;
    runStart();
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 32'h3000 + 32'(4 * i));
    checkOutput("endpc early done", 32'(done), 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h3010);
    checkOutput("endpc done",      32'(done), 32'd1);
    checkOutput("endpc instr_cnt", instr_cnt, 32'd5);

    $display("[TB] watchdog");
    end_pc_en = 1'b0;
    runStart();
    repeat (MAX_CYCLES - 1) applyStimulus(1'b0, 1'b0, '0);
    checkOutput("wd early timeout", 32'(timeout), 32'd0);
    checkOutput("wd early cycles",  cycle_cnt,    32'd99);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("wd timeout",   32'(timeout),   32'd1);
    checkOutput("wd done",      32'(done),      32'd0);
    checkOutput("wd cycle_cnt", cycle_cnt,      32'd100);
    checkOutput("wd cpu_reset", 32'(cpu_reset), 32'd1);
    applyStimulus(1'b0, 1'b1, 32'h1234);
    checkOutput("wd frozen cycles", cycle_cnt, 32'd100);
    checkOutput("wd frozen instrs", instr_cnt, 32'd0);

    $display("[TB] halt on the last allowed cycle");
    end_pc_en = 1'b1;
    end_pc    = 32'h7000;
    runStart();
    repeat (MAX_CYCLES - 1) applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 32'h7000);
    checkOutput("last done",      32'(done),    32'd1);
    checkOutput("last timeout",   32'(timeout), 32'd0);
    checkOutput("last cycle_cnt", cycle_cnt,    32'd100);
    checkOutput("last instr_cnt", instr_cnt,    32'd1);

    $display("[TB] repeats across bubbles and interrupted repeats");
    end_pc_en = 1'b0;
    runStart();
    applyStimulus(1'b0, 1'b1, 32'h4000);
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 32'h4000);
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 32'h4000);
    checkOutput("bubble done",      32'(done), 32'd1);
    checkOutput("bubble instr_cnt", instr_cnt, 32'd3);
    checkOutput("bubble cycle_cnt", cycle_cnt, 32'd6);
    runStart();
    applyStimulus(1'b0, 1'b1, 32'h5000);
    applyStimulus(1'b0, 1'b1, 32'h5000);
    applyStimulus(1'b0, 1'b1, 32'h5004);
    applyStimulus(1'b0, 1'b1, 32'h5000);
    applyStimulus(1'b0, 1'b1, 32'h5000);
    checkOutput("interrupted done", 32'(done), 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h5000);
    checkOutput("interrupted final done", 32'(done), 32'd1);
    checkOutput("interrupted instr_cnt",  instr_cnt, 32'd6);
    runStart();
    applyStimulus(1'b0, 1'b1, 32'h5000);
    applyStimulus(1'b0, 1'b1, 32'h5000);
    checkOutput("tracker cleared done", 32'(done), 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h5000);
    checkOutput("tracker rerun done", 32'(done), 32'd1);

    $display("[TB] asynchronous reset mid-run, then clean reruns");
    runStart();
    applyStimulus(1'b0, 1'b1, 32'h6000);
    applyStimulus(1'b0, 1'b1, 32'h6004);
    #2 reset = 1'b0;
    #1 checkResetValues("midrun reset");
    @(negedge clk);
    reset = 1'b1;
    repeat (2) applyStimulus(1'b0, 1'b0, '0);
    checkOutput("idle cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("idle running",   32'(running),   32'd0);
    runStart();
    repeat (3) applyStimulus(1'b0, 1'b1, 32'h8000);
    checkOutput("rerun done", 32'(done), 32'd1);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("restart done",      32'(done),      32'd0);
    checkOutput("restart cycle_cnt", cycle_cnt,      32'd0);
    checkOutput("restart instr_cnt", instr_cnt,      32'd0);
    checkOutput("restart cpu_reset", 32'(cpu_reset), 32'd1);
    repeat (RST_CYCLES) applyStimulus(1'b0, 1'b0, '0);
    checkOutput("restart running", 32'(running), 32'd1);
    applyStimulus(1'b1, 1'b1, 32'h9000);
    checkOutput("start in run ignored", 32'(running), 32'd1);
    repeat (3) applyStimulus(1'b0, 1'b1, 32'h8000);
    checkOutput("final done",      32'(done), 32'd1);
    checkOutput("final instr_cnt", instr_cnt, 32'd4);
    checkOutput("final cycle_cnt", cycle_cnt, 32'd4);

    repeat (2) @(negedge clk);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
